clock_input_ctrl: RTL and testbench

- Front-end stage directly upstream of the BCD time counter.
- Conditions three raw push-buttons (minute, hour, start) through synchronisers and debouncers.
- Produces the counter's control inputs: single-cycle inc_min / inc_hour pulses, a start run level, and an inc_min_auto pulse once per 60 s from a clock-driven prescaler.

---
 rtl/clock_input_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clock_input_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clock_input_ctrl.sv
// Button front end for the BCD time counter: sync, debounce, press pulses,
// run/set toggle and the seconds prescaler. Optional AUTOREPEAT_EN adds held-button repeats.
module clock_input_ctrl #(
    parameter int unsigned DIV_SEC      = 50000000,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_CYC   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_min_raw,
    input  logic       btn_hour_raw,
    input  logic       btn_start_raw,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       inc_min_auto,
    output logic       start,
    output logic       sec_tick,
    output logic [5:0] sec_count
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
    localparam int unsigned PW = $clog2(DIV_SEC);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(DIV_SEC - 1);

    // Bit order for the per-button vectors: 0 = minute, 1 = hour, 2 = start.
    logic [2:0]    raw, s1_q, s2_q, db_q, db_d, prev_q, armed_q, armed_d, rise;
    logic [1:0]    valid_q;
    logic [DW-1:0] cnt_q [3];
    logic [DW-1:0] cnt_d [3];
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic          start_q, tick_q, tick_d, auto_q, auto_d, min_q, hour_q;
    logic [1:0]    rep_pulse;

    assign raw = {btn_start_raw, btn_hour_raw, btn_min_raw};

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) db_d[i] = s2_q[i];
                else                     cnt_d[i] = cnt_q[i] + DW'(1);
            end
            // A button only arms once it has been seen released after reset,
            // so a press held through reset never produces a pulse.
            armed_d[i] = armed_q[i] | (valid_q[1] & ~s2_q[i] & ~db_q[i]);
        end
    end

    assign rise = db_q & ~prev_q & armed_q;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        auto_d  = 1'b0;
        if (!start_q || rise[2]) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (presc_q == PS_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d  = '0;
                auto_d = 1'b1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_CYC) ? REPEAT_DELAY : REPEAT_CYC;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RC = RW'(REPEAT_CYC);

    logic [RW-1:0] rep_q [2];
    logic [RW-1:0] rep_d [2];
    logic [1:0]    first_q, first_d;

    // rep_q counts cycles since the last pulse; zero means idle.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            rep_d[i]     = rep_q[i];
            first_d[i]   = first_q[i];
            rep_pulse[i] = 1'b0;
            if (!db_q[i] || start_q) begin
                rep_d[i]   = '0;
                first_d[i] = 1'b0;
            end else if (rise[i]) begin
                rep_d[i]   = RW'(1);
                first_d[i] = 1'b1;
            end else if (rep_q[i] != '0) begin
                if (rep_q[i] == (first_q[i] ? RD : RC)) begin
                    rep_pulse[i] = 1'b1;
                    rep_d[i]     = RW'(1);
                    first_d[i]   = 1'b0;
                end else begin
                    rep_d[i] = rep_q[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q   <= '{default: '0};
            first_q <= '0;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end
`else
    logic unused_rep;
    assign unused_rep = (REPEAT_DELAY != REPEAT_CYC);
    assign rep_pulse  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            valid_q <= '0;
            cnt_q   <= '{default: '0};
            presc_q <= '0;
            sec_q   <= '0;
            start_q <= 1'b0;
            tick_q  <= 1'b0;
            auto_q  <= 1'b0;
            min_q   <= 1'b0;
            hour_q  <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            db_q    <= db_d;
            prev_q  <= db_q;
            armed_q <= armed_d;
            valid_q <= {valid_q[0], 1'b1};
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            start_q <= start_q ^ rise[2];
            tick_q  <= tick_d;
            auto_q  <= auto_d;
            min_q   <= (rise[0] & ~start_q) | rep_pulse[0];
            hour_q  <= (rise[1] & ~start_q) | rep_pulse[1];
        end
    end

    assign inc_min      = min_q;
    assign inc_hour     = hour_q;
    assign inc_min_auto = auto_q;
    assign start        = start_q;
    assign sec_tick     = tick_q;
    assign sec_count    = sec_q;
endmodule

// File: tb/tb_clock_input_ctrl.sv
// Directed bench for clock_input_ctrl with DIV_SEC=10, DEBOUNCE_CYC=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_input_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bm = 1'b0, bh = 1'b0, bs = 1'b0;
    logic       inc_min, inc_hour, inc_min_auto, start, sec_tick;
    logic [5:0] sec_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit m, h, s;
        bit em, eh;
    } vec_t;
    vec_t tbl[$];

    int  t, e_s;
    bit  run, e_t, e_a;

    clock_input_ctrl #(
        .DIV_SEC(10),
        .DEBOUNCE_CYC(4),
        .REPEAT_DELAY(20),
        .REPEAT_CYC(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_min_raw(bm),
        .btn_hour_raw(bh),
        .btn_start_raw(bs),
        .inc_min(inc_min),
        .inc_hour(inc_hour),
        .inc_min_auto(inc_min_auto),
        .start(start),
        .sec_tick(sec_tick),
        .sec_count(sec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int em, input int eh, input int ea,
                           input int es, input int et, input int esec);
        chk({tag, " inc_min"}, int'(inc_min), em);
        chk({tag, " inc_hour"}, int'(inc_hour), eh);
        chk({tag, " inc_min_auto"}, int'(inc_min_auto), ea);
        chk({tag, " start"}, int'(start), es);
        chk({tag, " sec_tick"}, int'(sec_tick), et);
        chk({tag, " sec_count"}, int'(sec_count), esec);
    endtask

    task automatic drive(input bit m, input bit h, input bit s);
        bm = m;
        bh = h;
        bs = s;
    endtask

    // Appends n rows; pm/ph give the row index where a pulse is expected (-1: none).
    task automatic seg(input int n, input bit m, input bit h, input bit s,
                       input int pm, input int ph);
        for (int i = 0; i < n; i++) tbl.push_back('{m, h, s, (i == pm), (i == ph)});
    endtask

    initial begin
        seg(6, 0, 0, 0, -1, -1);
        seg(10, 1, 0, 0, 7, -1);
        seg(12, 0, 0, 0, -1, -1);
        seg(3, 0, 1, 0, -1, -1);
        seg(2, 0, 0, 0, -1, -1);
        seg(10, 0, 1, 0, -1, 7);
        seg(12, 0, 0, 0, -1, -1);
        seg(10, 1, 1, 0, 7, 7);
        seg(12, 0, 0, 0, -1, -1);

        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            chk_all($sformatf("vec%0d", i), int'(tbl[i].em), int'(tbl[i].eh), 0, 0, 0, 0);
            drive(tbl[i].m, tbl[i].h, tbl[i].s);
            @(negedge clk);
        end

        // Run a full minute, press minute while running, then stop on a terminal count.
        for (int r = 0; r <= 960; r++) begin
            t   = r - 7;
            run = (r >= 7) && (r < 917);
            e_t = run && (t > 0) && (t % 10 == 0);
            e_a = run && (t > 0) && (t % 600 == 0);
            e_s = run ? (t / 10) % 60 : 0;
            chk_all($sformatf("run r=%0d", r), 0, 0, int'(e_a), int'(run), int'(e_t), e_s);
            drive((r >= 627) && (r < 637), 1'b0, (r < 8) || ((r >= 910) && (r < 918)));
            @(negedge clk);
        end

        // Reset while counting with the minute button held.
        for (int r = 0; r <= 30; r++) begin
            t   = r - 7;
            run = (r >= 7);
            e_t = run && (t > 0) && (t % 10 == 0);
            e_s = run ? (t / 10) % 60 : 0;
            chk_all($sformatf("pre-rst r=%0d", r), 0, 0, 0, int'(run), int'(e_t), e_s);
            if (r < 30) begin
                drive(r >= 10, 1'b0, r < 8);
                @(negedge clk);
            end
        end
        rst_n = 1'b0;
        #1;
        chk_all("async rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk_all("in rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int r = 0; r < 20; r++) begin
            chk_all($sformatf("held r=%0d", r), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        for (int r = 0; r < 24; r++) begin
            chk_all($sformatf("repress r=%0d", r), int'(r == 17), 0, 0, 0, 0, 0);
            drive((r >= 10) && (r < 20), 1'b0, 1'b0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
